// File: rtl/uart_pkg.sv
// Shared definitions for the uart_ctrl peripheral: register offsets, STATUS/CTRL
// bit positions, FSM state encoding shared by TX and RX, and divisor clamping.
package uart_pkg;

  localparam logic [2:0] OFF_DATA    = 3'd0;
  localparam logic [2:0] OFF_STATUS  = 3'd1;
  localparam logic [2:0] OFF_CTRL    = 3'd2;
  localparam logic [2:0] OFF_DIVISOR = 3'd3;

  localparam int STAT_RX_VALID  = 0;
  localparam int STAT_TX_BUSY   = 1;
  localparam int STAT_TX_DONE   = 2;
  localparam int STAT_OVERRUN   = 3;
  localparam int STAT_FRAME_ERR = 4;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  localparam logic [15:0] MIN_DIVISOR = 16'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_e;

  // Divisors below the minimum would make the RX half-bit wait collapse to zero.
  function automatic logic [15:0] clamp_divisor(input logic [15:0] d);
    return (d < MIN_DIVISOR) ? MIN_DIVISOR : d;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, falling-edge start detect, mid-bit sampling.
// Emits one-cycle strobes for a delivered byte or a framing error.
module uart_rx
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        sys_rstn,
  input  logic        rxd_i,
  input  logic [15:0] divisor_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  output logic        frame_err_o
);

  logic        sync1_q, sync2_q, prev_q;
  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d, div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        fall;

  assign fall = prev_q & ~sync2_q;

  always_ff @(posedge clk) begin
    if (!sys_rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= MIN_DIVISOR;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, so the synchronizer chain shifts correctly.
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    // NOTE: defaulting every _d to its _q first keeps this block from inferring latches.
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      S_IDLE: if (fall) begin
        state_d = S_START;
        div_d   = divisor_i;
        cnt_d   = (divisor_i >> 1) - 16'd1;
      end
      S_START: if (cnt_q == '0) begin
        if (sync2_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
          cnt_d   = div_q - 16'd1;
          bit_d   = '0;
        end
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
      S_DATA: if (cnt_q == '0) begin
        shift_d = {sync2_q, shift_q[7:1]};
        cnt_d   = div_q - 16'd1;
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_STOP;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
      S_STOP: if (cnt_q == '0) state_d = S_IDLE;
              else             cnt_d   = cnt_q - 16'd1;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_valid_o = (state_q == S_STOP) && (cnt_q == '0) &&  sync2_q;
    frame_err_o  = (state_q == S_STOP) && (cnt_q == '0) && !sync2_q;
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped 8N1 UART: TX FSM, register file, RX holding storage and irq.
// Define UART_RX_FIFO_EN to replace the single RX holding register with a FIFO.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int DEFAULT_DIVISOR = 2604,
  parameter int RX_FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        sys_rstn,
  input  logic [2:0]  addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_result,
  output logic        irq,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  logic [15:0] divisor_q;
  logic [1:0]  ctrl_q;
  logic        tx_done_q, overrun_q, frame_err_q;
  logic [7:0]  clr;
  logic        pop, rx_valid, overrun_evt;
  logic [7:0]  rx_head, rx_byte;
  logic [2:0]  rx_count3;
  logic        rx_byte_valid, rx_frame_err;
  logic        unused_bits;

  assign clr         = (write_enable && addr == OFF_STATUS) ? write_data[7:0] : 8'd0;
  assign pop         = clr[STAT_RX_VALID];
  assign unused_bits = ^write_data[31:16];

  // ---------------- TX FSM ----------------
  uart_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_busy, tx_start, tx_fin;

  assign tx_busy  = (tx_state_q != S_IDLE);
  assign tx_start = write_enable && (addr == OFF_DATA) && !tx_busy;

  always_ff @(posedge clk) begin
    if (!sys_rstn) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= MIN_DIVISOR;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    unique case (tx_state_q)
      S_IDLE: if (tx_start) begin
        tx_state_d = S_START;
        tx_div_d   = divisor_q;
        tx_cnt_d   = divisor_q - 16'd1;
        tx_shift_d = write_data[7:0];
      end
      S_START: if (tx_cnt_q == '0) begin
        tx_state_d = S_DATA;
        tx_cnt_d   = tx_div_q - 16'd1;
        tx_bit_d   = '0;
      end else begin
        tx_cnt_d = tx_cnt_q - 16'd1;
      end
      S_DATA: if (tx_cnt_q == '0) begin
        tx_cnt_d = tx_div_q - 16'd1;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = S_STOP;
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end
      end else begin
        tx_cnt_d = tx_cnt_q - 16'd1;
      end
      S_STOP: if (tx_cnt_q == '0) tx_state_d = S_IDLE;
              else                tx_cnt_d   = tx_cnt_q - 16'd1;
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_fin = (tx_state_q == S_STOP) && (tx_cnt_q == '0);
    unique case (tx_state_q)
      S_START: uart_txd = 1'b0;
      S_DATA:  uart_txd = tx_shift_q[0];
      default: uart_txd = 1'b1;
    endcase
  end

  // ---------------- RX ----------------
  uart_rx u_rx (
    .clk          (clk),
    .sys_rstn     (sys_rstn),
    .rxd_i        (uart_rxd),
    .divisor_i    (divisor_q),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_byte_valid),
    .frame_err_o  (rx_frame_err)
  );

`ifdef UART_RX_FIFO_EN
  localparam int PTR_W = $clog2(RX_FIFO_DEPTH);

  logic [7:0]       fifo_mem [RX_FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q, count_after_pop;
  logic [7:0]       count_wide;
  logic             pop_eff, push_ok;

  // Pop is applied before the push, so a full FIFO popped this cycle still accepts.
  assign pop_eff         = pop && (count_q != '0);
  assign count_after_pop = count_q - (PTR_W+1)'(pop_eff);
  assign push_ok         = rx_byte_valid && (count_after_pop != (PTR_W+1)'(RX_FIFO_DEPTH));
  assign overrun_evt     = rx_byte_valid && !push_ok;

  always_ff @(posedge clk) begin
    if (!sys_rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop_eff) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      count_q <= count_after_pop + (PTR_W+1)'(push_ok);
    end
  end

  // NOTE: storage array carries no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= rx_byte;
  end

  assign count_wide = 8'(count_q);
  assign rx_valid   = (count_q != '0);
  assign rx_head    = fifo_mem[rd_ptr_q];
  assign rx_count3  = (count_wide > 8'd7) ? 3'd7 : count_wide[2:0];
`else
  logic [7:0] rx_data_q;
  logic       rx_valid_q, rx_keep, unused_cfg;

  assign rx_keep     = rx_valid_q & ~pop;
  assign overrun_evt = rx_byte_valid & rx_keep;
  assign unused_cfg  = (RX_FIFO_DEPTH == 0);

  always_ff @(posedge clk) begin
    if (!sys_rstn) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else if (rx_byte_valid && !rx_keep) begin
      rx_data_q  <= rx_byte;
      rx_valid_q <= 1'b1;
    end else begin
      rx_valid_q <= rx_keep;
    end
  end

  assign rx_valid  = rx_valid_q;
  assign rx_head   = rx_data_q;
  assign rx_count3 = 3'd0;
`endif

  // ---------------- Registers ----------------
  always_ff @(posedge clk) begin
    if (!sys_rstn) begin
      divisor_q   <= clamp_divisor(16'(DEFAULT_DIVISOR));
      ctrl_q      <= '0;
      tx_done_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (write_enable && addr == OFF_CTRL)    ctrl_q    <= write_data[1:0];
      if (write_enable && addr == OFF_DIVISOR) divisor_q <= clamp_divisor(write_data[15:0]);
      // Hardware set takes priority over a same-cycle write-1-to-clear.
      tx_done_q   <= tx_fin       | (tx_done_q   & ~clr[STAT_TX_DONE]);
      overrun_q   <= overrun_evt  | (overrun_q   & ~clr[STAT_OVERRUN]);
      frame_err_q <= rx_frame_err | (frame_err_q & ~clr[STAT_FRAME_ERR]);
    end
  end

  logic [7:0] status;
  always_comb begin
    status                 = '0;
    status[STAT_RX_VALID]  = rx_valid;
    status[STAT_TX_BUSY]   = tx_busy;
    status[STAT_TX_DONE]   = tx_done_q;
    status[STAT_OVERRUN]   = overrun_q;
    status[STAT_FRAME_ERR] = frame_err_q;
    status[7:5]            = rx_count3;
  end

  always_comb begin
    read_result = '0;
    case (addr)
      OFF_DATA:    read_result = {24'd0, rx_head};
      OFF_STATUS:  read_result = {24'd0, status};
      OFF_CTRL:    read_result = {30'd0, ctrl_q};
      OFF_DIVISOR: read_result = {16'd0, divisor_q};
      default:     read_result = '0;
    endcase
  end

  assign irq = (rx_valid & ctrl_q[CTRL_RX_IE]) | (tx_done_q & ctrl_q[CTRL_TX_IE]);

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed self-checking bench for uart_ctrl at DIVISOR=4; expectations adapt
// to the UART_RX_FIFO_EN build.
module tb_uart_ctrl;

  logic        clk = 1'b0;
  logic        sys_rstn;
  logic [2:0]  addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_result;
  logic        irq;
  logic        txd, rxd, rxd_drv, loop_en;

  int n_total = 0;
  int n_pass  = 0;

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  uart_ctrl #(.DEFAULT_DIVISOR(2604), .RX_FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .sys_rstn     (sys_rstn),
    .addr         (addr),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_result  (read_result),
    .irq          (irq),
    .uart_rxd     (rxd),
    .uart_txd     (txd)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    addr = a; write_data = d; write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = read_result;
  endtask

  task automatic wait_status(input int idx, input logic val, input int budget, output int cycles);
    logic [31:0] s;
    cycles = 0;
    bus_read(3'd1, s);
    while (s[idx] !== val && cycles < budget) begin
      @(negedge clk);
      cycles++;
      bus_read(3'd1, s);
    end
    check("wait_status_bound", {63'd0, s[idx] === val}, 64'd1);
  endtask

  task automatic tx_byte(input logic [7:0] b);
    int c;
    bus_write(3'd0, {24'd0, b});
    wait_status(1, 1'b0, 100, c);
    repeat (4) @(negedge clk);
  endtask

  task automatic capture_frame(output logic [39:0] line, output logic [39:0] busy);
    for (int i = 0; i < 40; i++) begin
      #1;
      line[i] = txd;
      busy[i] = read_result[1];
      @(negedge clk);
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = f[i];
      repeat (4) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    logic [39:0] line, busy;
    int          lat;

    sys_rstn = 1'b0; addr = '0; write_enable = 1'b0; write_data = '0;
    loop_en = 1'b0; rxd_drv = 1'b1;
    repeat (3) @(negedge clk);
    sys_rstn = 1'b1;

    // Reset state
    bus_read(3'd1, r); check("rst_status", 64'(r), 64'h0);
    bus_read(3'd2, r); check("rst_ctrl", 64'(r), 64'h0);
    bus_read(3'd3, r); check("rst_divisor", 64'(r), 64'd2604);
    bus_read(3'd5, r); check("rst_off5", 64'(r), 64'h0);
    check("rst_txd", 64'(txd), 64'd1);
    check("rst_irq", 64'(irq), 64'd0);
    @(negedge clk);

    // Divisor clamp
    bus_write(3'd3, 32'd1);
    bus_read(3'd3, r); check("div_clamp", 64'(r), 64'd4);
    @(negedge clk);

    // TX 0xA5 with TX-done interrupt
    bus_write(3'd2, 32'd2);
    bus_write(3'd0, 32'hA5);
    addr = 3'd1;
    capture_frame(line, busy);
    check("tx_a5_line", 64'(line), 64'hFF0F00F0F0);
    check("tx_a5_busy", 64'(busy), 64'hFFFFFFFFFF);
    #1;
    check("tx_a5_status", 64'(read_result), 64'h04);
    check("tx_a5_irq", 64'(irq), 64'd1);

    // Back-to-back 0xC3; a 0x55 write mid-frame must be ignored
    @(negedge clk);
    bus_write(3'd0, 32'hC3);
    fork
      capture_frame(line, busy);
      begin
        repeat (9) @(negedge clk);
        bus_write(3'd0, 32'h55);
      end
    join
    check("tx_c3_line", 64'(line), 64'hFFF0000FF0);
    bus_read(3'd1, r); check("tx_c3_status", 64'(r), 64'h04);
    @(negedge clk);
    bus_write(3'd1, 32'h4);
    bus_read(3'd1, r); check("tx_done_w1c", 64'(r), 64'h0);
    check("tx_irq_cleared", 64'(irq), 64'd0);
    @(negedge clk);

    // Loopback 0x3C with RX interrupt
    loop_en = 1'b1;
    bus_write(3'd2, 32'd1);
    bus_write(3'd0, 32'h3C);
    wait_status(0, 1'b1, 200, lat);
    check("rx_latency", {63'd0, (lat >= 40 && lat <= 42)}, 64'd1);
    check("lb_irq", 64'(irq), 64'd1);
    bus_read(3'd0, r); check("lb_data", 64'(r), 64'h3C);
    @(negedge clk);
    bus_write(3'd1, 32'h1);
    bus_read(3'd1, r); check("lb_rx_valid_clr", 64'(r[0]), 64'd0);
    check("lb_irq_clr", 64'(irq), 64'd0);
    @(negedge clk);
    bus_write(3'd1, 32'h1F);

    // Two bytes without a pop
    tx_byte(8'h11);
    tx_byte(8'h22);
    bus_read(3'd0, r); check("two_head", 64'(r), 64'h11);
`ifdef UART_RX_FIFO_EN
    bus_read(3'd1, r); check("fifo_status", 64'(r & 32'hF9), 64'h41);
    @(negedge clk);
    bus_write(3'd1, 32'h1);
    bus_read(3'd0, r); check("fifo_second", 64'(r), 64'h22);
    bus_read(3'd1, r); check("fifo_count1", 64'(r & 32'hF9), 64'h21);
    @(negedge clk);
    bus_write(3'd1, 32'h1);
    bus_read(3'd1, r); check("fifo_empty", 64'(r & 32'hF9), 64'h0);
`else
    bus_read(3'd1, r); check("hold_overrun", 64'(r & 32'hF9), 64'h09);
`endif
    @(negedge clk);
    bus_write(3'd1, 32'h1F);
    bus_read(3'd1, r); check("clear_all", 64'(r), 64'h0);
    @(negedge clk);

    // Stop bit 0
    loop_en = 1'b0;
    drive_frame(8'h5A, 1'b0);
    bus_read(3'd1, r); check("frame_err", 64'(r), 64'h10);
    @(negedge clk);
    bus_write(3'd1, 32'h10);

    // One-cycle glitch, then a good frame
    rxd_drv = 1'b0;
    @(negedge clk);
    rxd_drv = 1'b1;
    repeat (20) @(negedge clk);
    bus_read(3'd1, r); check("glitch_no_flags", 64'(r), 64'h0);
    @(negedge clk);
    drive_frame(8'h96, 1'b1);
    bus_read(3'd0, r); check("post_glitch_data", 64'(r), 64'h96);
    bus_read(3'd1, r); check("post_glitch_status", 64'(r & 32'h1F), 64'h01);
    @(negedge clk);
    bus_write(3'd1, 32'h1F);

    // Reset mid-TX
    bus_write(3'd0, 32'h00);
    repeat (10) @(negedge clk);
    #1;
    check("mid_tx_low", 64'(txd), 64'd0);
    sys_rstn = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_txd", 64'(txd), 64'd1);
    bus_read(3'd1, r); check("rst_mid_status", 64'(r), 64'h0);
    sys_rstn = 1'b1;
    @(negedge clk);
    bus_read(3'd3, r); check("rst_mid_divisor", 64'(r), 64'd2604);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Memory-mapped 8N1 UART peripheral occupying the bridge's UART device slot, alongside the timer, switches, LED, nixie and buttons devices. It serialises bytes written by the CPU onto `uart_txd` and deserialises `uart_rxd` into a receive holding register. It raises `irq` into the bridge's hwirq vector on receive-ready or transmit-done. Baud rate is set at runtime by a divisor register.

## Interface
- `DEFAULT_DIVISOR`, 2604: reset value of DIVISOR, in clocks per bit.
- `RX_FIFO_DEPTH`, 4: receive FIFO depth, power of two. Used only with `UART_RX_FIFO_EN`.
- `clk`  in  1  sole clock.
- `sys_rstn`  in  1  reset, synchronous, active-low.
- `addr`  in  3  word offset; the bridge address is sliced as `addr[4:2]` at the instance.
- `write_enable`  in  1  register write strobe, valid for one cycle.
- `write_data`  in  32  write data.
- `read_result`  out  32  combinational read of the register selected by `addr`.
- `irq`  out  1  level interrupt to the bridge.
- `uart_rxd`  in  1  asynchronous serial input.
- `uart_txd`  out  1  serial output; idles high.

## Operation
Register map by word offset:
- 0 DATA
  - Write: loads a TX byte from `write_data[7:0]`, but only if `tx_busy`=0. Otherwise the write is ignored.
  - Read: returns the RX byte (head entry) zero-extended. Reading has no side effect.
- 1 STATUS
  - [0] `rx_valid`: writing 1 pops or clears the entry.
  - [1] `tx_busy`: read-only.
  - [2] `tx_done`: write-1-to-clear (W1C).
  - [3] `overrun`: W1C.
  - [4] `frame_err`: W1C.
  - [7:5] FIFO count when FIFO enabled, else 0.
- 2 CTRL
  - [0] RX interrupt enable.
  - [1] TX-done interrupt enable.
- 3 DIVISOR
  - [15:0] clocks per bit.
  - Written values below 4 are stored as 4.
- Offsets 4–7: read 0; writes ignored.

Interrupt: `irq = (rx_valid & CTRL[0]) | (tx_done & CTRL[1])`.

TX FSM: IDLE → START → DATA → STOP → IDLE.
- Each bit lasts DIVISOR cycles. DIVISOR is latched on entry to START.
- Data is sent LSB first.
- On STOP completion: `tx_done` is set and `tx_busy` is cleared.

RX path: `uart_rxd` passes through a 2-flop synchronizer before the FSM.

RX FSM: IDLE → START → DATA → STOP → IDLE.
- IDLE: waits for a synchronized falling edge. DIVISOR is latched at this point.
- START: waits DIVISOR/2 cycles, then samples.
  - Sample high: treated as a glitch, return to IDLE.
- DATA: 8 samples, each DIVISOR cycles apart (mid-bit), shifted in LSB first.
- STOP: one sample.
  - Stop bit 1: the byte is delivered.
  - Stop bit 0: `frame_err` is set and the byte is discarded.
- Delivery while the holding register or FIFO is full: `overrun` is set, the new byte is dropped and stored data is kept.

Simultaneous events:
- W1C pop and a delivery in the same cycle: the pop is applied first, then the delivery, so no overrun.
- W1C of `tx_done` in the same cycle it is set: set wins.

## Timing
- Reset values:
  - `uart_txd`=1, `irq`=0, `read_result` follows registers.
  - STATUS=0, CTRL=0, DIVISOR=`DEFAULT_DIVISOR`.
  - Both FSMs in IDLE; FIFO empty.
- TX:
  - A DATA write at edge N gives `tx_busy`=1 and `uart_txd`=0 from edge N+1.
  - The frame lasts exactly 10×DIVISOR cycles.
  - `tx_busy` falls and `tx_done` rises on the same edge the stop bit ends.
  - Back-to-back TX: a write in the first cycle after `tx_busy` falls starts the next frame with no idle gap beyond 1 cycle.
- RX:
  - Latency from the `uart_rxd` falling edge to `rx_valid`=1 is 2 + DIVISOR/2 + 9×DIVISOR + 1 cycles, ±1 for edge-detect phase.
  - `irq` follows `rx_valid` in the same cycle; `irq` is combinational from the flags.
- DIVISOR writes mid-frame do not affect the frame in progress.
- Reset mid-frame: both FSMs return to IDLE and `uart_txd`=1 on the next edge. The partial byte is lost.

## Configuration
- `UART_RX_FIFO_EN` defined:
  - RX uses an `RX_FIFO_DEPTH`-entry FIFO.
  - DATA reads the head entry; STATUS[0] W1C pops one entry.
  - `rx_valid` = not empty; `overrun` is set on a push when full.
  - STATUS[7:5] = count, saturating at 7.
- `UART_RX_FIFO_EN` undefined:
  - Single holding register.
  - STATUS[7:5]=0.

## Structure
- Package `uart_pkg`:
  - Register offsets.
  - STATUS/CTRL bit indices.
  - FSM state encodings, shared by TX and RX.
  - `MIN_DIVISOR`=4.
- Sub-module `uart_rx`: synchronizer, RX FSM and byte/frame-error output strobe.
- TX FSM, registers, FIFO or holding register, and irq logic live in `uart_ctrl`.

## Test plan
All scenarios use DIVISOR=4 unless stated.
- TX 0xA5: `uart_txd` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. `tx_busy` is high for 40 cycles, then `tx_done`=1. With CTRL=2, `irq`=1 until STATUS is written with 0x4.
- Loopback (`uart_rxd` tied to `uart_txd`), CTRL=1, send 0x3C: DATA reads 0x3C, `rx_valid`=1, `irq`=1. Writing STATUS=0x1 clears both.
- Receive 0x11 then 0x22 without a pop, holding-register build: DATA reads 0x11 and `overrun`=1. FIFO build: count=2, and two pops yield 0x11 then 0x22.
- Frame with stop bit 0: `frame_err`=1, `rx_valid` stays 0. A 1-cycle low glitch on `uart_rxd` gives no flags and the RX FSM back in IDLE.
- DATA write 0x55 during an active frame: ignored, and the current frame completes unchanged.
- Write DIVISOR=1: reads back 4.
- Assert `sys_rstn`=0 mid-TX: `uart_txd`=1 and `tx_busy`=0 next edge; DIVISOR=2604 after release.
